sub_store_packer: RTL and testbench

Narrows a 32-bit store operand to byte, halfword or word width and commits it to a word-only data memory port. Sub-word stores use a read-modify-write sequence. Sits between the MEM-stage store path and the data memory/bridge, and reports misaligned stores (AdES) to the exception logic. It is the writer-side counterpart of the load-data extender: it truncates and positions data where the extender selects and widens it.

---
 rtl/sub_store_packer.sv | 171 +++++++++++++++++
 tb/tb_sub_store_packer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sub_store_packer.sv
// Narrows a 32-bit store to byte/half/word and commits it to a word-only memory port,
// using read-modify-write for sub-word stores. Define MISALIGN_TRAP_EN to trap misaligned stores.
module sub_store_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    logic [2:0]  state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        reject_s;

    // Replace only the addressed lane of the old word; half stores ignore lane[0]
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [15:0] data,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]        = data[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16]   = data;
            default: merged = old_word;
        endcase
        return merged;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic misalign_s;

    // Misalignment detection for the trapping configuration
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    assign reject_s = (req_size == SZ_BAD) || misalign_s;
`else
    assign reject_s = (req_size == SZ_BAD);
`endif

    // Next-state and datapath selection
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        lane_d      = lane_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_addr_d = {req_addr[31:2], 2'b00};
                    wdata_d    = req_wdata[15:0];
                    size_d     = req_size;
                    lane_d     = req_addr[1:0];
                    if (reject_s) begin
                        state_d = ST_ERR;
                    end else if (req_size == SZ_WORD) begin
                        state_d     = ST_WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_rvalid) begin
                    state_d     = ST_WRITE;
                    mem_wdata_d = merge_lane(mem_rdata, wdata_q, size_q, lane_q);
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_wack) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR == state_q ? ST_IDLE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered copies of the state being entered
    always_comb begin
        mem_rd_d = (state_d == ST_READ);
        mem_wr_d = (state_d == ST_WRITE);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= 32'h0000_0000;
            wdata_q     <= 16'h0000;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            mem_wdata_q <= 32'h0000_0000;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sub_store_packer.sv
// Randomized self-checking bench for sub_store_packer; expectations come from a byte-level
// memory model and a cycle schedule derived from the store's wait states.
module tb_sub_store_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [16];

    sub_store_packer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Little-endian byte-array view of the store
    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [31:0] wd, input logic [1:0] sz);
        logic [7:0] b [4];
        int base;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (sz == 2'b10) begin
            b[addr[1:0]] = wd[7:0];
        end else if (sz == 2'b01) begin
            base = addr[1] ? 2 : 0;
            b[base]     = wd[7:0];
            b[base + 1] = wd[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic model_reject(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'b01 && addr[0]) return 1'b1;
        if (sz == 2'b00 && addr[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Issue one store at a negedge with req_ready high; checks every cycle until ready returns
    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz,
                            input int rlat, input int wlat, input logic use_lit, input logic [31:0] lit);
        logic        rej;
        logic        exp_rd, exp_wr;
        logic [31:0] exp_word;
        int idx, rd_end, wr_start, wr_end, done_c, ready_c;
        idx      = int'(addr[5:2]);
        rej      = model_reject(addr, sz);
        exp_word = model_store(mem[idx], addr, wd, sz);
        if (rej) begin
            rd_end = 0; wr_start = 0; wr_end = -1; done_c = -1; ready_c = 2;
        end else begin
            rd_end   = (sz != 2'b00) ? rlat + 1 : 0;
            wr_start = rd_end + 1;
            wr_end   = wr_start + wlat;
            done_c   = wr_end + 1;
            ready_c  = done_c + 1;
        end
        chk("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_size = sz;
        for (int c = 1; c <= ready_c; c++) begin
            @(negedge clk);
            exp_rd = (c <= rd_end);
            exp_wr = (c >= wr_start) && (c <= wr_end);
            chk("mem_rd", mem_rd, exp_rd);
            chk("mem_wr", mem_wr, exp_wr);
            chk("done", done, c == done_c);
            chk("err", err, rej && c == 1);
            chk("req_ready", req_ready, c == ready_c);
            if (exp_rd || exp_wr) chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (exp_wr) begin
                chk("mem_wdata", mem_wdata, exp_word);
                if (use_lit) chk("mem_wdata_lit", mem_wdata, lit);
            end
            // Junk requests while busy must be ignored; responses outside their phase too
            if (c < ready_c) begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_size  = 2'($urandom_range(0, 3));
            end else begin
                req_valid = 1'b0;
            end
            mem_rdata  = (c == rd_end) ? mem[idx] : $urandom;
            mem_rvalid = (c == rd_end) ? 1'b1 : (exp_rd ? 1'b0 : 1'($urandom_range(0, 1)));
            mem_wack   = (c == wr_end) ? 1'b1 : (exp_wr ? 1'b0 : 1'($urandom_range(0, 1)));
        end
        if (!rej) mem[idx] = exp_word;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00;
        mem_rdata = 32'h0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        chk("pin_byte", model_store(32'h1122_3344, 32'h1006, 32'h0000_00AB, 2'b10), 32'h11AB_3344);
        chk("pin_reject", model_reject(32'h1000, 2'b11), 1'b1);

        do_store(32'h0000_1004, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b1, 32'hDEAD_BEEF);
        mem[1] = 32'h1122_3344;
        do_store(32'h0000_1006, 32'h0000_00AB, 2'b10, 0, 0, 1'b1, 32'h11AB_3344);
        mem[1] = 32'h1122_3344;
        do_store(32'h0000_1007, 32'h0000_00AB, 2'b10, 0, 0, 1'b1, 32'hAB22_3344);
        mem[0] = 32'h1122_3344;
        do_store(32'h0000_1002, 32'hFFFF_5566, 2'b01, 3, 2, 1'b1, 32'h5566_3344);
        mem[0] = 32'h1122_3344;
        do_store(32'h0000_1001, 32'h0000_CAFE, 2'b01, 0, 0, 1'b1, 32'h1122_CAFE);
        do_store(32'h0000_1000, 32'h1234_5678, 2'b11, 0, 0, 1'b0, 32'h0);

        // Reset while the read strobe is up abandons the store
        req_valid = 1'b1; req_addr = 32'h0000_1005; req_wdata = 32'h0000_0077; req_size = 2'b10;
        mem_rvalid = 1'b0; mem_wack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_rd", mem_rd, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rd", mem_rd, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b1);
        chk("mid_rst_wr", mem_wr, 1'b0);
        mem_rvalid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_rd", mem_rd, 1'b0);
            chk("post_rst_wr", mem_wr, 1'b0);
            chk("post_rst_ready", req_ready, 1'b1);
        end

        for (int n = 0; n < 300; n++) begin
            do_store({$urandom_range(0, 3) == 0 ? $urandom : 32'h0000_2000} | 32'($urandom_range(0, 63)),
                     $urandom, 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
